// File: rtl/sd30xx_rtc_scheduler.sv
// SD30xx RTC transaction sequencer.
// Periodically reads the seven BCD time registers into a coherent snapshot.
// Runs the unlock / time-write / relock sequence on user request.
// At most one engine transaction is in flight, and a set request wins over a poll.
module sd30xx_rtc_scheduler #(
  parameter logic [7:0]  DEVICE_ID      = 8'h64,
  parameter int unsigned POLL_CYCLES    = 5_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_req,
  input  logic [55:0] set_time,
  output logic [55:0] time_out,
  output logic        time_valid,
  output logic        busy,
  output logic        err,
  output logic        err_timeout,
  output logic        i2c_wr_req,
  output logic        i2c_rd_req,
  output logic [15:0] i2c_addr,
  output logic        i2c_addr_mode,
  output logic [7:0]  i2c_wr_data,
  output logic [7:0]  i2c_device_id,
  input  logic [7:0]  i2c_rd_data,
  input  logic        i2c_rw_done,
  input  logic        i2c_ack
);

  localparam int unsigned PW = $clog2(POLL_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, FINISH
  } state_t;

  state_t        state;
  logic [PW-1:0] poll_cnt;
  logic          poll_tick;
  logic          set_pending;
  logic          poll_pending;
  logic [55:0]   set_buf;
  logic [55:0]   wr_buf;
  logic [55:0]   shadow;
  logic [2:0]    idx;
  logic [3:0]    step;
  logic [TW-1:0] tmo;
  logic          seq_ok;
  logic          seq_rd;
  logic [7:0]    step_addr;
  logic [7:0]    step_data;
  logic [2:0]    step_byte;

  assign busy          = (state != IDLE);
  assign i2c_addr_mode = 1'b0;
  assign i2c_device_id = DEVICE_ID;
  assign poll_tick     = (poll_cnt == PW'(POLL_CYCLES - 1));

  // Free-running poll interval counter; it keeps running while busy
  always_ff @(posedge clk) begin
    if (rst)            poll_cnt <= '0;
    else if (poll_tick) poll_cnt <= '0;
    else                poll_cnt <= poll_cnt + 1'b1;
  end

  // Register address / data for each step of the write sequence
  always_comb begin
    step_byte = 3'(step - 4'd2);
    step_addr = {5'd0, step_byte};
    step_data = wr_buf[{step_byte, 3'b000} +: 8];
    case (step)
      4'd0:    begin step_addr = 8'h10; step_data = 8'h80; end
      4'd1:    begin step_addr = 8'h0F; step_data = 8'h84; end
      4'd9:    begin step_addr = 8'h0F; step_data = 8'h00; end
      4'd10:   begin step_addr = 8'h10; step_data = 8'h00; end
      default: ;
    endcase
  end

  // Sequencer FSM with registered engine requests and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      set_pending  <= 1'b0;
      poll_pending <= 1'b1;
      set_buf      <= '0;
      wr_buf       <= '0;
      shadow       <= '0;
      idx          <= '0;
      step         <= '0;
      tmo          <= '0;
      seq_ok       <= 1'b0;
      seq_rd       <= 1'b0;
      time_out     <= '0;
      time_valid   <= 1'b0;
      err          <= 1'b0;
      err_timeout  <= 1'b0;
      i2c_wr_req   <= 1'b0;
      i2c_rd_req   <= 1'b0;
      i2c_addr     <= '0;
      i2c_wr_data  <= '0;
    end else begin
      i2c_wr_req <= 1'b0;
      i2c_rd_req <= 1'b0;
      time_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (set_pending) begin
            // Snapshot the request so a set_req arriving mid-write cannot tear it
            set_pending <= 1'b0;
            wr_buf      <= set_buf;
            step        <= '0;
            seq_ok      <= 1'b1;
            seq_rd      <= 1'b0;
            state       <= WR_ISSUE;
          end else if (poll_pending) begin
            poll_pending <= 1'b0;
            idx          <= '0;
            seq_ok       <= 1'b1;
            seq_rd       <= 1'b1;
            state        <= RD_ISSUE;
          end
        end

        RD_ISSUE: begin
          i2c_rd_req <= 1'b1;
          i2c_addr   <= {8'h00, 5'd0, idx};
          tmo        <= TW'(TIMEOUT_CYCLES);
          state      <= RD_WAIT;
        end

        RD_WAIT: begin
          if (i2c_rw_done) begin
            if (i2c_ack) begin
              err    <= 1'b1;
              seq_ok <= 1'b0;
              state  <= FINISH;
            end else begin
              shadow[{idx, 3'b000} +: 8] <= i2c_rd_data;
              if (idx == 3'd6) begin
                state <= FINISH;
              end else begin
                idx   <= idx + 3'd1;
                state <= RD_ISSUE;
              end
            end
          end else begin
            tmo <= tmo - 1'b1;
            if (tmo == TW'(1)) begin
              err         <= 1'b1;
              err_timeout <= 1'b1;
              seq_ok      <= 1'b0;
              state       <= FINISH;
            end
          end
        end

        WR_ISSUE: begin
          i2c_wr_req  <= 1'b1;
          i2c_addr    <= {8'h00, step_addr};
          i2c_wr_data <= step_data;
          tmo         <= TW'(TIMEOUT_CYCLES);
          state       <= WR_WAIT;
        end

        WR_WAIT: begin
          if (i2c_rw_done) begin
            if (i2c_ack) begin
              // A NACK before the unlock completes aborts; after it, always relock
              err    <= 1'b1;
              seq_ok <= 1'b0;
              if (step <= 4'd1 || step == 4'd10) begin
                state <= FINISH;
              end else begin
                step  <= (step <= 4'd8) ? 4'd9 : 4'd10;
                state <= WR_ISSUE;
              end
            end else if (step == 4'd10) begin
              if (seq_ok) poll_pending <= 1'b1;
              state <= FINISH;
            end else begin
              step  <= step + 4'd1;
              state <= WR_ISSUE;
            end
          end else begin
            tmo <= tmo - 1'b1;
            if (tmo == TW'(1)) begin
              err         <= 1'b1;
              err_timeout <= 1'b1;
              seq_ok      <= 1'b0;
              state       <= FINISH;
            end
          end
        end

        FINISH: begin
          if (seq_ok) begin
            err         <= 1'b0;
            err_timeout <= 1'b0;
            if (seq_rd) begin
              time_out   <= shadow;
              time_valid <= 1'b1;
            end
          end
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase

      // Placed after the FSM so a trigger in the same cycle as a clear wins
      if (poll_tick) poll_pending <= 1'b1;
      if (set_req) begin
        set_pending <= 1'b1;
        set_buf     <= set_time;
      end
    end
  end

endmodule

// File: tb/tb_sd30xx_rtc_scheduler.sv
// Self-checking bench for sd30xx_rtc_scheduler with a behavioural RTC/engine model.
module tb_sd30xx_rtc_scheduler;

  localparam int unsigned POLL = 1000;
  localparam int unsigned TMO  = 60;

  logic        clk = 1'b0;
  logic        rst;
  logic        set_req;
  logic [55:0] set_time;
  logic [55:0] time_out;
  logic        time_valid, busy, err, err_timeout;
  logic        i2c_wr_req, i2c_rd_req, i2c_addr_mode;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_wr_data, i2c_device_id, i2c_rd_data;
  logic        i2c_rw_done, i2c_ack;

  sd30xx_rtc_scheduler #(
    .DEVICE_ID(8'h64),
    .POLL_CYCLES(POLL),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .set_req(set_req), .set_time(set_time),
    .time_out(time_out), .time_valid(time_valid), .busy(busy),
    .err(err), .err_timeout(err_timeout),
    .i2c_wr_req(i2c_wr_req), .i2c_rd_req(i2c_rd_req), .i2c_addr(i2c_addr),
    .i2c_addr_mode(i2c_addr_mode), .i2c_wr_data(i2c_wr_data),
    .i2c_device_id(i2c_device_id), .i2c_rd_data(i2c_rd_data),
    .i2c_rw_done(i2c_rw_done), .i2c_ack(i2c_ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Transaction log: {is_write, addr[7:0], data[7:0]}
  logic [16:0] log_q[$];
  logic [16:0] exp_q[$];

  logic [7:0]  rtc [0:6];
  logic [55:0] new_regs;
  int          load_seq = 0;
  int          nack_at  = -1;
  int          hold_at  = -1;
  int          tv_count = 0;
  int          viol     = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Protocol monitor
  initial begin
    bit prev_req = 0;
    bit prev_tv  = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (time_valid) tv_count++;
        if (time_valid && prev_tv) viol++;
        if (i2c_rd_req && i2c_wr_req) viol++;
        if ((i2c_rd_req || i2c_wr_req) && prev_req) viol++;
        if ((i2c_rd_req || i2c_wr_req) && i2c_addr[15:8] != 8'h00) viol++;
      end
      prev_req = i2c_rd_req || i2c_wr_req;
      prev_tv  = time_valid;
    end
  end

  // I2C engine + RTC register model
  logic [16:0] r_e;
  logic [7:0]  r_a;
  bit          r_nk;
  int          r_seen = 0;
  initial begin
    i2c_rw_done = 1'b0;
    i2c_ack     = 1'b0;
    i2c_rd_data = 8'h00;
    forever begin
      @(negedge clk);
      if (r_seen != load_seq) begin
        for (int i = 0; i < 7; i++) rtc[i] = 8'(new_regs >> (8 * i));
        r_seen = load_seq;
      end
      while (!rst && (i2c_rd_req || i2c_wr_req)) begin
        r_a  = i2c_addr[7:0];
        r_e  = {i2c_wr_req, r_a, i2c_wr_req ? i2c_wr_data : 8'h00};
        r_nk = (log_q.size() == nack_at);
        if (log_q.size() == hold_at) begin
          log_q.push_back(r_e);
          repeat (TMO + 20) @(negedge clk);
          i2c_rw_done = 1'b1;
          i2c_rd_data = 8'hEE;
          @(negedge clk);
          i2c_rw_done = 1'b0;
        end else begin
          log_q.push_back(r_e);
          repeat ($urandom_range(1, 4)) @(negedge clk);
          i2c_rw_done = 1'b1;
          i2c_ack     = r_nk;
          if (!r_e[16]) i2c_rd_data = (r_a < 8'd7) ? rtc[r_a[2:0]] : 8'h00;
          else if (!r_nk && r_a < 8'd7) rtc[r_a[2:0]] = r_e[7:0];
          @(negedge clk);
          i2c_rw_done = 1'b0;
          i2c_ack     = 1'b0;
        end
      end
    end
  end

  function automatic logic [55:0] rand_time();
    logic [55:0] t;
    for (int i = 0; i < 7; i++)
      t[8*i +: 8] = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    return t;
  endfunction

  function automatic logic [16:0] wr_entry(input logic [55:0] t, input int s);
    case (s)
      0:       return {1'b1, 8'h10, 8'h80};
      1:       return {1'b1, 8'h0F, 8'h84};
      9:       return {1'b1, 8'h0F, 8'h00};
      10:      return {1'b1, 8'h10, 8'h00};
      default: return {1'b1, 8'(s - 2), 8'(t >> (8 * (s - 2)))};
    endcase
  endfunction

  task automatic exp_reads(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, 8'(i), 8'h00});
  endtask

  task automatic exp_writes(input logic [55:0] t, input int nack_step);
    int s = 0;
    bit fin = 0;
    while (!fin) begin
      exp_q.push_back(wr_entry(t, s));
      if (s == nack_step) begin
        if (s <= 1 || s == 10) fin = 1;
        else if (s <= 8) s = 9;
        else s = 10;
      end else if (s == 10) fin = 1;
      else s++;
    end
  endtask

  task automatic load_time(input logic [55:0] t);
    new_regs = t;
    load_seq++;
  endtask

  task automatic pulse_set(input logic [55:0] t);
    set_time = t;
    set_req  = 1'b1;
    @(negedge clk);
    set_req  = 1'b0;
  endtask

  task automatic wait_poll_start(input string tag);
    int c = 0;
    while (c < POLL + 50 && !busy) begin @(negedge clk); c++; end
    check({tag, " start"}, c < POLL + 50, 1);
  endtask

  task automatic wait_size(input int n, input int budget, input string tag);
    int c = 0;
    while (c < budget && log_q.size() < n) begin @(negedge clk); c++; end
    check({tag, " size"}, c < budget, 1);
  endtask

  task automatic wait_done(input int n, input int budget, input string tag);
    int c = 0;
    while (c < budget && !(log_q.size() >= n && !busy)) begin @(negedge clk); c++; end
    check({tag, " done"}, c < budget, 1);
  endtask

  task automatic compare_log(input int base, input string tag);
    check({tag, " count"}, log_q.size(), base + exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < log_q.size()) check($sformatf("%s txn%0d", tag, i), log_q[base + i], exp_q[i]);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [55:0] t0, ts, ta, tb, tn, model_time;
    int base, tv0;
    rst = 1'b1;
    set_req = 1'b0;
    set_time = '0;
    t0 = 56'h24_06_15_03_92_30_45;
    load_time(t0);
    repeat (3) @(negedge clk);

    check("rst time_out", time_out, 0);
    check("rst time_valid", time_valid, 0);
    check("rst busy", busy, 0);
    check("rst err", err, 0);
    check("rst err_timeout", err_timeout, 0);
    check("rst wr_req", i2c_wr_req, 0);
    check("rst rd_req", i2c_rd_req, 0);
    check("rst addr", i2c_addr, 0);
    check("rst wr_data", i2c_wr_data, 0);
    check("addr_mode", i2c_addr_mode, 0);
    check("device_id", i2c_device_id, 8'h64);

    // First poll straight after reset
    rst = 1'b0;
    exp_reads(7);
    wait_done(7, 300, "poll1");
    compare_log(0, "poll1");
    model_time = t0;
    check("poll1 time_out", time_out, model_time);
    check("poll1 tv_count", tv_count, 1);
    check("poll1 err", err, 0);

    // Set request arriving mid-read
    ts = 56'h25_01_01_03_08_00_00;
    wait_poll_start("set");
    base = log_q.size();
    tv0 = tv_count;
    wait_size(base + 2, 100, "set");
    pulse_set(ts);
    exp_reads(7); exp_writes(ts, -1); exp_reads(7);
    wait_done(base + 25, 800, "set");
    compare_log(base, "set");
    model_time = ts;
    check("set time_out", time_out, model_time);
    check("set tv_count", tv_count, tv0 + 2);
    check("set err", err, 0);

    // Two set requests while busy: only the latest is written
    ta = rand_time();
    tb = rand_time();
    wait_poll_start("AB");
    base = log_q.size();
    pulse_set(ta);
    repeat (3) @(negedge clk);
    pulse_set(tb);
    exp_reads(7); exp_writes(tb, -1); exp_reads(7);
    wait_done(base + 25, 800, "AB");
    compare_log(base, "AB");
    model_time = tb;
    check("AB time_out", time_out, model_time);

    // NACK on read index 3
    tn = rand_time();
    load_time(tn);
    base = log_q.size();
    tv0 = tv_count;
    nack_at = base + 3;
    wait_poll_start("rdnack");
    exp_reads(4);
    wait_done(base + 4, 300, "rdnack");
    compare_log(base, "rdnack");
    check("rdnack err", err, 1);
    check("rdnack tv_count", tv_count, tv0);
    check("rdnack time_out", time_out, model_time);
    nack_at = -1;
    base = log_q.size();
    wait_poll_start("rdclean");
    exp_reads(7);
    wait_done(base + 7, 300, "rdclean");
    compare_log(base, "rdclean");
    model_time = tn;
    check("rdclean time_out", time_out, model_time);
    check("rdclean err", err, 0);
    check("rdclean tv_count", tv_count, tv0 + 1);

    // NACK on write step 4 forces the relock steps
    ts = rand_time();
    base = log_q.size();
    nack_at = base + 7 + 4;
    wait_poll_start("wrnack");
    wait_size(base + 1, 100, "wrnack");
    pulse_set(ts);
    exp_reads(7); exp_writes(ts, 4);
    wait_done(base + 14, 600, "wrnack");
    compare_log(base, "wrnack");
    check("wrnack err", err, 1);
    nack_at = -1;

    // Withheld rw_done: timeout, then a late rw_done while idle
    tn = rand_time();
    load_time(tn);
    base = log_q.size();
    tv0 = tv_count;
    hold_at = base;
    wait_poll_start("tmo");
    wait_done(base + 1, TMO + 40, "tmo");
    check("tmo err", err, 1);
    check("tmo err_timeout", err_timeout, 1);
    repeat (40) @(negedge clk);
    check("late busy", busy, 0);
    check("late err", err, 1);
    check("late count", log_q.size(), base + 1);
    check("late tv_count", tv_count, tv0);
    hold_at = -1;
    base = log_q.size();
    wait_poll_start("tmoclean");
    exp_reads(7);
    wait_done(base + 7, 300, "tmoclean");
    compare_log(base, "tmoclean");
    model_time = tn;
    check("tmoclean time_out", time_out, model_time);
    check("tmoclean err", err, 0);
    check("tmoclean err_timeout", err_timeout, 0);

    // Randomized polls, some with a set request injected mid-read
    for (int it = 0; it < 4; it++) begin
      tn = rand_time();
      load_time(tn);
      model_time = tn;
      base = log_q.size();
      wait_poll_start("rnd");
      exp_reads(7);
      if ($urandom_range(0, 1) == 1) begin
        ts = rand_time();
        wait_size(base + 1 + $urandom_range(0, 5), 100, "rnd");
        pulse_set(ts);
        exp_writes(ts, -1); exp_reads(7);
        model_time = ts;
      end
      wait_done(base + exp_q.size(), 800, "rnd");
      compare_log(base, $sformatf("rnd%0d", it));
      check("rnd time_out", time_out, model_time);
      check("rnd err", err, 0);
    end

    check("protocol violations", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sd30xx_rtc_scheduler.md
Name: sd30xx_rtc_scheduler

Overview:
- Sequencer for the single-transaction I2C register engine (one byte per wr_req/rd_req, completion on rw_done) that talks to the SD30xx RTC.
- Polls the seven BCD time registers periodically and publishes a coherent 56-bit snapshot.
- Accepts user set-time requests and runs the RTC write-unlock, time-write and relock sequence.
- Arbitrates set versus poll: set has priority, and at most one I2C transaction is outstanding.

Parameters:
- DEVICE_ID, 8'h64, 8-bit RTC write address.
- POLL_CYCLES, 5_000_000, clk cycles between poll triggers (100 ms at 50 MHz).
- TIMEOUT_CYCLES, 1_000_000, maximum cycles from request to rw_done before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- set_req  in  1  one-cycle pulse, request a time write
- set_time  in  56  {year,month,day,week,hour,min,sec}, BCD, sampled on set_req
- time_out  out  56  last good snapshot, same packing as set_time
- time_valid  out  1  one-cycle pulse when time_out updates
- busy  out  1  high whenever not in IDLE
- err  out  1  sticky; set on NACK or timeout, cleared by next successful sequence
- err_timeout  out  1  sticky; set on timeout, cleared with err
- i2c_wr_req  out  1  one-cycle write request to engine
- i2c_rd_req  out  1  one-cycle read request to engine
- i2c_addr  out  16  register address in [7:0], [15:8] = 0
- i2c_addr_mode  out  1  constant 0 (8-bit addressing)
- i2c_wr_data  out  8  write byte
- i2c_device_id  out  8  constant DEVICE_ID
- i2c_rd_data  in  8  read byte, valid with i2c_rw_done
- i2c_rw_done  in  1  one-cycle transaction-complete pulse
- i2c_ack  in  1  high = NACK occurred in the transaction

Behaviour:
- Reset values: time_out=0, time_valid=0, busy=0, err=0, err_timeout=0, i2c_wr_req=0, i2c_rd_req=0, i2c_addr=0, i2c_wr_data=0. Internal: state=IDLE, poll counter=0, set_pending=0, poll_pending=1 (first poll right after reset).
- Poll timer: free-running 0..POLL_CYCLES-1. At terminal count it sets poll_pending and wraps to 0. It never stops, including while busy.
- set_req in any state sets set_pending and captures set_time into set_buf. A later set_req before service overwrites set_buf; only the latest is written.
- Arbitration in IDLE: set_pending first (clear set_pending, enter WR_ISSUE at step 0), else poll_pending (clear poll_pending, enter RD_ISSUE at index 0). Triggers arriving in the same cycle as a clear win (pending stays 1).
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, FINISH.
- RD_ISSUE: i2c_rd_req=1 for exactly one cycle, i2c_addr=index (0..6). Load timeout counter, go to RD_WAIT.
- RD_WAIT: on i2c_rw_done:
  - if i2c_ack: set err, go to FINISH with no update.
  - else write i2c_rd_data to shadow byte[index]; index<6 -> index+1, RD_ISSUE; index==6 -> FINISH with update.
- Read packing: byte[0]=sec at [7:0], up to byte[6]=year at [55:48].
- WR_ISSUE: i2c_wr_req=1 for one cycle with (addr,data) per step:
  - step 0: 0x10 <- 0x80
  - step 1: 0x0F <- 0x84
  - steps 2..8: 0x00..0x06 <- set_buf bytes sec..year
  - step 9: 0x0F <- 0x00
  - step 10: 0x10 <- 0x00
- WR_WAIT, on rw_done without NACK: step<10 -> step+1; step 10 -> FINISH (success), poll_pending=1 so a read-back follows.
- WR_WAIT, on NACK: set err.
  - NACK at step 0 or 1 -> FINISH.
  - NACK at steps 2..8 -> jump to step 9 to relock.
  - NACK at step 9 or 10 -> continue the remaining relock step.
  - Success requires zero NACKs across the sequence.
- Timeout: counter decrements in *_WAIT. Reaching 0 without rw_done sets err and err_timeout, then FINISH. A late rw_done arriving in IDLE is ignored.
- FINISH (one cycle):
  - successful read: time_out <= shadow, time_valid=1.
  - any successful sequence: err=0, err_timeout=0.
  - then IDLE. Min gap between engine requests = 1 cycle (WAIT->ISSUE).
- Request outputs are never high for two consecutive cycles. i2c_wr_req and i2c_rd_req are never high together.
- rst mid-sequence: immediate return to reset values. time_out is lost; set_pending is cleared.

Test Plan:
- Reset then model returns 0x45,0x30,0x92,0x03,0x15,0x06,0x24 with no NACK -> seven rd_req at addr 0..6; time_out=56'h24_06_15_03_92_30_45; one time_valid pulse; err=0.
- set_req with set_time=56'h25_01_01_03_08_00_00 mid-read -> read completes first; then exactly 11 wr_req pairs (10,80),(0F,84),(00,00),(01,00),(02,08),(03,03),(04,01),(05,01),(06,25),(0F,00),(10,00); then a read-back burst.
- Two set_req while busy with values A then B -> only B written; one write sequence.
- NACK on read index 3 -> err=1, no time_valid, time_out unchanged, no rd_req for addr 4; next clean poll clears err.
- NACK on write step 4 -> next requests are steps 9 and 10 only; err=1.
- rw_done withheld TIMEOUT_CYCLES -> err=err_timeout=1, busy drops; a late rw_done is ignored; the next poll proceeds normally.
